// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR flop command scheduler.
//   state_t   : scheduler FSM states
//   OP_SET/OP_RST : command op encoding (1 = set, 0 = reset)
//   idx_width : bit-index width needed to address an N_BITS-wide flop bank
package sr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_GAP    = 2'd2,
    ST_VERIFY = 2'd3
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  function automatic int idx_width(input int n_bits);
    return (n_bits <= 2) ? 1 : $clog2(n_bits);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority requester for this decision
//   gnt : one-hot grant (all-zero when nothing requests)
//   win : index of the granted requester (0 when nothing requests)
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] win
);

  logic             found;
  logic [PTR_W-1:0] cand;

  // Scan requesters starting at ptr, wrapping; the first requester wins.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        win       = cand;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_scheduler.sv
// Arbitrating pulse sequencer for a bank of SR flops.
// Grants one set/reset command at a time (round-robin), drives a registered
// PULSE_W-cycle pulse on the target bit's s or r line, keeps GAP_W all-low
// cycles, then checks q feedback in a one-cycle VERIFY state.
//   req_valid/req_op/req_idx : per-requester command (idx slice i*IDX_W)
//   req_ready                : one-hot accept strobe
//   s_out/r_out              : registered drives to the flop bank
//   q_in                     : flop feedback, sampled only in VERIFY
//   busy/done/err/err_idx    : status; err_idx holds the last failing bit
//   dbg_state                : current FSM state
//
// Handshake: a command is taken in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is offered only in IDLE, only to the
// arbiter winner, and never while rst is high; a requester not granted keeps
// its command pending and may change op/idx until it is accepted.
module sr_cmd_scheduler
  import sr_sched_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int N_BITS  = 8,
  parameter  int PULSE_W = 2,
  parameter  int GAP_W   = 1,
  localparam int IDX_W   = idx_width(N_BITS),
  localparam int PTR_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_BITS-1:0]      s_out,
  output logic [N_BITS-1:0]      r_out,
  input  logic [N_BITS-1:0]      q_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [IDX_W-1:0]       err_idx,
  output logic [1:0]             dbg_state
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

  state_t             state_q, state_d;
  logic [3:0]         phase_q, phase_d;
  logic               op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_BITS-1:0]  s_q, s_d, r_q, r_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;

  logic [N_REQ-1:0]   gnt;
  logic [PTR_W-1:0]   win;
  logic               win_op;
  logic [IDX_W-1:0]   win_idx;
  logic               verify_ok;

  // One-hot decode of a bit index; indices >= N_BITS decode to all-zero,
  // which is how out-of-range commands end up with no pulse.
  function automatic logic [N_BITS-1:0] bit_sel(input logic [IDX_W-1:0] i);
    logic [N_BITS-1:0] v;
    v = '0;
    for (int b = 0; b < N_BITS; b++) v[b] = (i == IDX_W'(b));
    return v;
  endfunction

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .win (win)
  );

  always_comb begin
    win_op  = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_op  = req_op[i];
        win_idx = req_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  // Out-of-range targets select no q bit and always fail verification.
  assign verify_ok = (|bit_sel(idx_q)) && ((|(q_in & bit_sel(idx_q))) == op_q);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    op_d      = op_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    s_d       = s_q;
    r_d       = r_q;
    err_idx_d = err_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          op_d     = win_op;
          idx_d    = win_idx;
          rr_ptr_d = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
          phase_d  = '0;
          s_d      = (win_op == OP_SET) ? bit_sel(win_idx) : '0;
          r_d      = (win_op == OP_RST) ? bit_sel(win_idx) : '0;
          state_d  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          s_d     = '0;
          r_d     = '0;
          state_d = (GAP_W == 0) ? ST_VERIFY : ST_GAP;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = ST_VERIFY;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_VERIFY: begin
        if (!verify_ok) err_idx_d = idx_q;
        state_d = ST_IDLE;
      end
      default: begin
        s_d     = '0;
        r_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      op_q      <= 1'b0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      s_q       <= '0;
      r_q       <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      s_q       <= s_d;
      r_q       <= r_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign s_out     = s_q;
  assign r_out     = r_q;
  assign req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_VERIFY);
  assign err       = done && !verify_ok;
  // Show the failing index in the same cycle as err, then hold it.
  assign err_idx   = err ? idx_q : err_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_cmd_scheduler.sv
module tb_sr_cmd_scheduler;
  localparam int N_REQ = 4;
  localparam int N_BITS = 8;
  localparam int IDX_W = 3;
  localparam int P = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst;
  logic [N_REQ-1:0] req_valid, req_op, req_ready;
  logic [N_REQ*IDX_W-1:0] req_idx;
  logic [N_BITS-1:0] s_out, r_out, q_in;
  logic busy, done, err;
  logic [IDX_W-1:0] err_idx;
  logic [1:0] dbg_state;

  logic [3:0] v6, op6, rdy6;
  logic [11:0] idx6;
  logic [5:0] s6, r6, q6;
  logic busy6, done6, err6;
  logic [2:0] eidx6;
  logic [1:0] dbg6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_cmd_scheduler #(.N_REQ(4), .N_BITS(8), .PULSE_W(2), .GAP_W(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .s_out(s_out), .r_out(r_out),
    .q_in(q_in), .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .dbg_state(dbg_state)
  );

  sr_cmd_scheduler #(.N_REQ(4), .N_BITS(6), .PULSE_W(2), .GAP_W(1)) u_dut6 (
    .clk(clk), .rst(rst), .req_valid(v6), .req_op(op6),
    .req_idx(idx6), .req_ready(rdy6), .s_out(s6), .r_out(r6),
    .q_in(q6), .busy(busy6), .done(done6), .err(err6), .err_idx(eidx6),
    .dbg_state(dbg6)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    req_valid = '0;
    v6 = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input bit op, input int idx);
    req_valid[i] = v;
    req_op[i] = op;
    req_idx[i*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL drain_timeout: busy=%0b after %0d cycles, want 0", busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    #2;
    checks++;
    if ({s_out, r_out, req_ready, busy, done, err, err_idx} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: s=%h r=%h rdy=%b busy=%b done=%b err=%b eidx=%0d want all 0",
               s_out, r_out, req_ready, busy, done, err, err_idx);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready_held: got %b want 0000", req_ready);
    end
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_out, r_out, busy, done, err, err_idx, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_release: s=%h r=%h busy=%b done=%b err=%b state=%0d want 0",
               s_out, r_out, busy, done, err, dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    q_in = '0;
    set_req(0, 1, 1, 3);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (s_out !== ((c <= P) ? 8'h08 : 8'h00) || r_out !== 8'h00) begin
        failures++;
        $display("FAIL single_pulse c%0d: s=%h r=%h want s=%h r=00", c, s_out, r_out,
                 (c <= P) ? 8'h08 : 8'h00);
      end
      checks++;
      if (done !== (c == 4) || err !== 1'b0 || busy !== (c <= 4)) begin
        failures++;
        $display("FAIL single_status c%0d: done=%b err=%b busy=%b want done=%b err=0 busy=%b",
                 c, done, err, busy, c == 4, c <= 4);
      end
      if (s_out[3]) q_in[3] = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_round_robin();
    int win_q[$];
    int cyc_q[$];
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1, i % 2, i + 2);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (!$onehot0(req_ready)) begin
        failures++;
        $display("FAIL rr_onehot c%0d: got %b want one-hot or zero", c, req_ready);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i]) begin
          win_q.push_back(i);
          cyc_q.push_back(c);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (win_q.size() < 5) begin
      failures++;
      $display("FAIL rr_count: got %0d accepts want >=5", win_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (win_q[k] != k % N_REQ || cyc_q[k] != 5 * k) begin
          failures++;
          $display("FAIL rr_grant %0d: winner=%0d cycle=%0d want winner=%0d cycle=%0d",
                   k, win_q[k], cyc_q[k], k % N_REQ, 5 * k);
        end
      end
    end
    drain();
  endtask

  task automatic test_verify_fail();
    do_reset();
    q_in = 8'h20;
    set_req(2, 1, 0, 5);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL vf_ready: got %b want 0100", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (r_out !== ((c <= P) ? 8'h20 : 8'h00) || s_out !== 8'h00) begin
        failures++;
        $display("FAIL vf_pulse c%0d: s=%h r=%h want s=00 r=%h", c, s_out, r_out,
                 (c <= P) ? 8'h20 : 8'h00);
      end
      checks++;
      if (done !== (c == 4) || err !== (c == 4)) begin
        failures++;
        $display("FAIL vf_status c%0d: done=%b err=%b want %b", c, done, err, c == 4);
      end
      if (c >= 4) begin
        checks++;
        if (err_idx !== 3'd5) begin
          failures++;
          $display("FAIL vf_err_idx c%0d: got %0d want 5", c, err_idx);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_hazard();
    int s_first, s_last, r_first, r_last, n_done;
    bit g1, g2;
    s_first = -1; s_last = -1; r_first = -1; r_last = -1; n_done = 0;
    do_reset();
    q_in = '0;
    set_req(1, 1, 1, 0);
    set_req(2, 1, 0, 0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checks++;
      if ((s_out & r_out) !== 8'h00) begin
        failures++;
        $display("FAIL hz_overlap c%0d: s=%h r=%h want s&r=00", c, s_out, r_out);
      end
      if (s_out[0]) begin
        if (s_first < 0) s_first = c;
        s_last = c;
        q_in[0] = 1'b1;
      end
      if (r_out[0]) begin
        if (r_first < 0) r_first = c;
        r_last = c;
        q_in[0] = 1'b0;
      end
      if (done) begin
        n_done++;
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL hz_err c%0d: got %b want 0", c, err);
        end
      end
      g1 = req_ready[1];
      g2 = req_ready[2];
      @(posedge clk);
      #1;
      if (g1) req_valid[1] = 1'b0;
      if (g2) req_valid[2] = 1'b0;
    end
    checks++;
    if (s_first != 1 || s_last != 2 || r_first != 6 || r_last != 7) begin
      failures++;
      $display("FAIL hz_timing: s=%0d..%0d r=%0d..%0d want s=1..2 r=6..7",
               s_first, s_last, r_first, r_last);
    end
    checks++;
    if (r_first - s_last < 2 || n_done != 2) begin
      failures++;
      $display("FAIL hz_gap: gap=%0d dones=%0d want gap>=2 dones=2", r_first - s_last, n_done);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int n_done;
    n_done = 0;
    do_reset();
    set_req(1, 1, 1, 7);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL ar_ready: got %b want 0010", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    checks++;
    if (s_out !== 8'h80) begin
      failures++;
      $display("FAIL ar_pulse: got %h want 80", s_out);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (s_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL ar_immediate: s=%h busy=%b done=%b rdy=%b want all 0",
               s_out, busy, done, req_ready);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL ar_no_done: got %0d done/busy cycles want 0", n_done);
    end
    @(posedge clk);
    #1 req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL ar_rr_ptr: got %b want 0001", req_ready);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_oor();
    do_reset();
    q6 = 6'h3F;
    v6[0] = 1'b1;
    op6[0] = 1'b1;
    idx6[2:0] = 3'd7;
    @(negedge clk);
    checks++;
    if (rdy6 !== 4'b0001) begin
      failures++;
      $display("FAIL oor_ready: got %b want 0001", rdy6);
    end
    @(posedge clk);
    #1 v6 = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (s6 !== 6'h00 || r6 !== 6'h00) begin
        failures++;
        $display("FAIL oor_pulse c%0d: s=%h r=%h want 00", c, s6, r6);
      end
      checks++;
      if (done6 !== (c == 4) || err6 !== (c == 4)) begin
        failures++;
        $display("FAIL oor_status c%0d: done=%b err=%b want %b", c, done6, err6, c == 4);
      end
      if (c >= 4) begin
        checks++;
        if (eidx6 !== 3'd7) begin
          failures++;
          $display("FAIL oor_err_idx c%0d: got %0d want 7", c, eidx6);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a command accepted at cycle a pulses on a+1..a+P,
  // completes at a+P+G+1; arbitration is "first valid from ptr onward".
  task automatic test_random();
    bit m_busy, m_op;
    int m_k, m_idx, m_ptr, m_eidx, w;
    logic [N_REQ-1:0] e_rdy;
    logic [N_BITS-1:0] e_s, e_r;
    logic e_busy, e_done, e_err;
    logic [IDX_W-1:0] e_eidx;
    m_busy = 0; m_op = 0; m_k = 0; m_idx = 0; m_ptr = 0; m_eidx = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N_REQ'($urandom_range(0, 15));
      req_op = N_REQ'($urandom_range(0, 15));
      req_idx = (N_REQ*IDX_W)'($urandom);
      q_in = N_BITS'($urandom_range(0, 255));
      @(negedge clk);
      w = -1;
      e_rdy = '0; e_s = '0; e_r = '0; e_busy = 0; e_done = 0; e_err = 0;
      e_eidx = IDX_W'(m_eidx);
      if (!m_busy) begin
        for (int j = 0; j < N_REQ; j++)
          if (w < 0 && req_valid[(m_ptr + j) % N_REQ]) w = (m_ptr + j) % N_REQ;
        if (w >= 0) e_rdy[w] = 1'b1;
      end else begin
        e_busy = 1;
        if (m_k <= P) begin
          if (m_op) e_s = N_BITS'(1) << m_idx;
          else e_r = N_BITS'(1) << m_idx;
        end
        e_done = (m_k == P + G + 1);
        e_err = e_done && (q_in[m_idx] != m_op);
        if (e_err) e_eidx = IDX_W'(m_idx);
      end
      checks++;
      if (req_ready !== e_rdy) begin
        failures++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, e_rdy);
      end
      checks++;
      if (s_out !== e_s || r_out !== e_r) begin
        failures++;
        $display("FAIL rnd_drive c%0d: s=%h r=%h want s=%h r=%h", c, s_out, r_out, e_s, e_r);
      end
      checks++;
      if (busy !== e_busy || done !== e_done || err !== e_err) begin
        failures++;
        $display("FAIL rnd_status c%0d: busy=%b done=%b err=%b want %b %b %b",
                 c, busy, done, err, e_busy, e_done, e_err);
      end
      checks++;
      if (err_idx !== e_eidx) begin
        failures++;
        $display("FAIL rnd_err_idx c%0d: got %0d want %0d", c, err_idx, e_eidx);
      end
      if (!m_busy && w >= 0) begin
        m_busy = 1;
        m_k = 1;
        m_op = req_op[w];
        m_idx = int'(req_idx[w*IDX_W +: IDX_W]);
        m_ptr = (w + 1) % N_REQ;
      end else if (m_busy) begin
        if (e_err) m_eidx = m_idx;
        if (m_k == P + G + 1) m_busy = 0;
        else m_k++;
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_idx = '0; q_in = '0;
    v6 = '0; op6 = '0; idx6 = '0; q6 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_verify_fail();
    test_hazard();
    test_async_reset();
    test_oor();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_cmd_scheduler.md
# sr_cmd_scheduler

Arbitrating sequencer for a bank of SR flip-flops (`srff_udp` instances). Several requesters issue set/reset commands for individual flop bits. The block grants one command at a time, round-robin, and drives a registered, width-controlled pulse onto the selected flop's `s` or `r` line. Before returning to idle it enforces a quiet gap and checks the flop's `q` feedback. It sits between the control logic and the SR bank and guarantees the bank never sees `s=r=1`.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `N_BITS`, default 8: number of SR flops in the bank (2..32).
- `PULSE_W`, default 2: cycles `s`/`r` is held high (1..15).
- `GAP_W`, default 1: all-low cycles after the pulse, before verify (0..15).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester command valid.
- `req_op`  in  N_REQ  per-requester op: 1 = set, 0 = reset.
- `req_idx`  in  N_REQ*IDX_W  per-requester target bit; IDX_W = $clog2(N_BITS); requester i occupies slice [i*IDX_W +: IDX_W].
- `req_ready`  out  N_REQ  one-hot accept strobe.
- `s_out`  out  N_BITS  to flop `s` inputs.
- `r_out`  out  N_BITS  to flop `r` inputs.
- `q_in`  in  N_BITS  flop `q` feedback, already synchronous to `clk`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on command completion.
- `err`  out  1  one-cycle pulse when verify fails, coincident with `done`.
- `err_idx`  out  IDX_W  bit index of the last failed verify; holds until the next failure.

## Operation
- FSM states: IDLE, PULSE, GAP, VERIFY.
- **IDLE**
  - If any `req_valid` is high, the round-robin arbiter picks a winner starting from `rr_ptr`.
  - `req_ready[winner]` goes high combinationally in this cycle. The handshake completes on valid & ready.
  - The block latches the winner's op and idx, sets `rr_ptr` = (winner+1) mod N_REQ and moves to PULSE.
- **PULSE**: lasts PULSE_W cycles. The block drives bit idx of `s_out` (op=1) or `r_out` (op=0); all other bits are low. Next state is GAP, or VERIFY when GAP_W=0.
- **GAP**: lasts GAP_W cycles with all `s_out`/`r_out` low. Next state is VERIFY.
- **VERIFY**: lasts 1 cycle.
  - `done` is high.
  - If `q_in[idx]` != op, `err` is high and `err_idx` is loaded with idx.
  - Next state is IDLE.
- An out-of-range idx (≥ N_BITS) is accepted but produces no pulse. It completes with `err`=1 and `err_idx` = idx truncated to IDX_W.
- Invariants, on every cycle:
  - `s_out & r_out` == 0.
  - `popcount(s_out | r_out)` ≤ 1.
  - `req_ready` is all-zero outside IDLE.
- A requester holding `req_valid` while not granted keeps its command. Changing op/idx while waiting is allowed; the values sampled at accept are the ones used.
- Back-to-back commands to the same bit with opposite ops are legal. GAP separates the two pulses.
- `rst` asserted at any time, including mid-PULSE:
  - `s_out`, `r_out`, `req_ready`, `busy`, `done`, `err` go to 0 immediately.
  - `err_idx` = 0, `rr_ptr` = 0, FSM = IDLE.
  - An interrupted command is dropped with no `done`.

## Timing
- Reset values: all outputs 0, `rr_ptr` = 0.
- Per-command cycle map, with accept at cycle 0:
  - `s_out`/`r_out` are high on cycles 1..PULSE_W. They are registered outputs with no combinational path from `req_*`.
  - Gap occupies cycles PULSE_W+1..PULSE_W+GAP_W.
  - VERIFY (`done`) is on cycle PULSE_W+GAP_W+1.
  - The next accept can occur no earlier than cycle PULSE_W+GAP_W+2.
- Throughput is 1 command per PULSE_W+GAP_W+2 cycles. With defaults: accept at 0, pulse at 1–2, gap at 3, done at 4, next accept at 5.
- `busy` is high from cycle 1 through the VERIFY cycle inclusive.
- `q_in` is sampled in the VERIFY cycle only.

## Structure
- The shared package `sr_sched_pkg` holds:
  - the state enum (IDLE/PULSE/GAP/VERIFY);
  - the op encoding constants OP_SET=1, OP_RST=0;
  - a function returning IDX_W from N_BITS.
- Sub-module `rr_arbiter`, parameterised by N_REQ. It takes req and ptr and returns a one-hot grant plus the winner index. It is purely combinational; the `rr_ptr` register stays in the top level.
- The top level also contains the FSM, a 4-bit phase counter (reused for PULSE and GAP) and the decoded registered output drivers.

## Test plan
- **Reset, then a single command.** Requester 0 sends set to bit 3, and the bench model sets q[3]. Expect `s_out` = 0x08 for 2 cycles, all low for 1 cycle, `done` at cycle 4, `err` = 0.
- **Round-robin.** All 4 requesters are valid continuously with distinct idx. Expect grants in order 0,1,2,3,0, with accepts 5 cycles apart.
- **Verify failure.** Requester 2 sends reset to bit 5 while the bench holds q[5] = 1. Expect `r_out` = 0x20 pulses, then `done` = `err` = 1 and `err_idx` = 5.
- **Set/reset hazard.** Requester 1 sends set bit 0 and requester 2 sends reset bit 0 back-to-back. Expect the two pulses separated by ≥ 1 all-low cycle, and `s_out & r_out` = 0 checked on every cycle.
- **Async reset mid-PULSE.** Assert `rst` on cycle 1 of a set to bit 7. Expect `s_out` = 0 before the next edge, no `done`, and `rr_ptr` = 0 afterwards.
- **Out-of-range idx.** With N_BITS = 6, send idx 7. Expect no pulse, then `done` = `err` = 1 with `err_idx` = 7.
